// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-16 registered distributor.
// Channel count, select width and the one-hot select decode.
package demux_pkg;

  localparam int NUM_CH = 16;
  localparam int SEL_W  = 4;

  typedef logic [SEL_W-1:0] sel_t;

  // One-hot decode of a channel index.
  function automatic logic [NUM_CH-1:0] sel_dec(sel_t sel);
    logic [NUM_CH-1:0] oh;
    oh = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One output channel: a single-entry holding register.
// A write wins over a drain so refill and drain can share a cycle.
module demux_slot #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_ready,
  output logic         valid,
  output logic [W-1:0] data
);

  // Occupancy: set on write, cleared on drain without refill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      valid <= 1'b0;
    else if (wr_en)
      valid <= 1'b1;
    else if (rd_ready)
      valid <= 1'b0;
  end

  // Payload: captured on write, otherwise keeps its last value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      data <= '0;
    else if (wr_en)
      data <= wr_data;
  end

endmodule

// File: rtl/demux1to16_reg.sv
// Registered 1-to-16 distributor with per-channel valid/ready.
// Select decode, addressed-channel ready mux and output packing.
module demux1to16_reg
  import demux_pkg::*;
#(
  parameter int W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic [W-1:0]      in_data,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [NUM_CH*W-1:0] out_data
);

  logic              accept;
  logic [NUM_CH-1:0] wr_en;

  // Only the addressed channel decides whether the word fits.
  always_comb begin
    in_ready = ~out_valid[in_sel] | out_ready[in_sel];
    accept   = in_valid & in_ready;
    wr_en    = accept ? sel_dec(sel_t'(in_sel)) : '0;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    demux_slot #(
      .W (W)
    ) u_slot (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en[i]),
      .wr_data  (in_data),
      .rd_ready (out_ready[i]),
      .valid    (out_valid[i]),
      .data     (out_data[i*W +: W])
    );
  end

endmodule
